// File: rtl/sifive_insight_tl_txn_tracker.sv
// Passive TileLink A/D transaction tracker: one entry per source ID, per-source latency,
// retirement reports and protocol-violation pulses. Nothing here drives the bus.
module sifive_insight_tl_txn_tracker #(
  parameter int SOURCE_BITS = 2,
  parameter int SIZE_BITS   = 3,
  parameter int BEAT_LG     = 3,
  parameter int LAT_BITS    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  output logic                   done_valid,
  output logic [SOURCE_BITS-1:0] done_source,
  output logic [2:0]             done_opcode,
  output logic [LAT_BITS-1:0]    done_latency,
  output logic                   done_error,
  output logic                   err_valid,
  output logic [3:0]             err_mask,
  output logic [SOURCE_BITS-1:0] err_a_source,
  output logic [SOURCE_BITS-1:0] err_d_source,
  output logic [SOURCE_BITS:0]   outstanding_cnt
);

  localparam int NENT  = 1 << SOURCE_BITS;
  localparam int CNT_W = ((1 << SIZE_BITS) > BEAT_LG) ? ((1 << SIZE_BITS) - BEAT_LG) : 1;
  localparam int OC_W  = SOURCE_BITS + 1;

  typedef enum logic { A_IDLE, A_BURST } a_state_t;
  typedef enum logic { D_IDLE, D_BURST } d_state_t;

  function automatic logic [CNT_W-1:0] beat_count(input logic has_data,
                                                  input logic [SIZE_BITS-1:0] size);
    logic [CNT_W-1:0] n;
    n = CNT_W'(1);
    if (has_data && (int'(size) > BEAT_LG))
      n = CNT_W'(1) << (int'(size) - BEAT_LG);
    return n;
  endfunction

  function automatic logic [LAT_BITS-1:0] sat_inc(input logic [LAT_BITS-1:0] v);
    return (&v) ? v : v + LAT_BITS'(1);
  endfunction

  a_state_t               a_st;
  d_state_t               d_st;
  logic [CNT_W-1:0]       a_cnt, d_cnt;
  logic [SOURCE_BITS-1:0] a_src_l, d_src_l;
  logic [2:0]             a_op_l;
  logic [SIZE_BITS-1:0]   a_size_l;
  logic                   d_hit_l, d_err_l;

  logic [NENT-1:0]        ent_vld;
  logic [2:0]             ent_op   [NENT];
  logic [2:0]             ent_dop  [NENT];
  logic [SIZE_BITS-1:0]   ent_size [NENT];
  logic [LAT_BITS-1:0]    ent_lat  [NENT];

  // Stage p0: decode this cycle's fires against registered tracker state
  logic                   a_fire_p0, a_first_p0, a_chg_p0, a_dup_p0, a_new_p0;
  logic [CNT_W-1:0]       a_beats_p0, d_beats_p0;
  logic                   d_fire_p0, d_first_p0, d_last_p0, d_hit_p0, d_hit_now_p0;
  logic                   d_miss_p0, d_mis_p0, d_err_now_p0, d_retire_p0, retire_same_p0;
  logic [SOURCE_BITS-1:0] d_tsrc_p0;
  logic [3:0]             err_mask_p0;

  assign a_fire_p0  = a_valid & a_ready;
  assign a_first_p0 = a_fire_p0 & (a_st == A_IDLE) & (a_opcode <= 3'd4);
  assign a_beats_p0 = beat_count(a_opcode <= 3'd3, a_size);
  assign a_chg_p0   = a_fire_p0 & (a_st == A_BURST) &
                      ((a_source != a_src_l) | (a_opcode != a_op_l) | (a_size != a_size_l));

  assign d_fire_p0  = d_valid & d_ready;
  assign d_first_p0 = d_fire_p0 & (d_st == D_IDLE);
  assign d_beats_p0 = beat_count(d_opcode == 3'd1, d_size);
  assign d_last_p0  = d_first_p0 ? (d_beats_p0 == CNT_W'(1))
                                 : (d_fire_p0 & (d_st == D_BURST) & (d_cnt == CNT_W'(1)));
  assign d_hit_p0   = ent_vld[d_source];
  assign d_miss_p0  = d_first_p0 & ~d_hit_p0;
  assign d_mis_p0   = d_first_p0 & d_hit_p0 &
                      ((d_opcode != ent_dop[d_source]) | (d_size != ent_size[d_source]));
  assign d_tsrc_p0     = d_first_p0 ? d_source : d_src_l;
  assign d_hit_now_p0  = d_first_p0 ? d_hit_p0 : d_hit_l;
  assign d_err_now_p0  = d_denied | d_corrupt | (d_first_p0 ? d_mis_p0 : d_err_l);
  assign d_retire_p0   = d_last_p0 & d_hit_now_p0 & ent_vld[d_tsrc_p0];

  // A retiring entry may be re-armed in the same cycle without counting as a duplicate
  assign retire_same_p0 = d_retire_p0 & (d_tsrc_p0 == a_source);
  assign a_dup_p0       = a_first_p0 & ent_vld[a_source] & ~retire_same_p0;
  assign a_new_p0       = a_first_p0 & (~ent_vld[a_source] | retire_same_p0);
  assign err_mask_p0    = {d_mis_p0, d_miss_p0, a_chg_p0, a_dup_p0};

  always_ff @(posedge clock) begin
    if (reset) begin
      a_st    <= A_IDLE;
      a_cnt   <= '0;
      d_st    <= D_IDLE;
      d_cnt   <= '0;
      d_hit_l <= 1'b0;
      d_err_l <= 1'b0;
    end else begin
      case (a_st)
        A_IDLE: if (a_first_p0 && (a_beats_p0 != CNT_W'(1))) begin
          a_st  <= A_BURST;
          a_cnt <= a_beats_p0 - CNT_W'(1);
        end
        A_BURST: if (a_fire_p0) begin
          if (a_cnt == CNT_W'(1)) a_st <= A_IDLE;
          a_cnt <= a_cnt - CNT_W'(1);
        end
        default: a_st <= A_IDLE;
      endcase
      case (d_st)
        D_IDLE: if (d_first_p0 && (d_beats_p0 != CNT_W'(1))) begin
          d_st    <= D_BURST;
          d_cnt   <= d_beats_p0 - CNT_W'(1);
          d_hit_l <= d_hit_p0;
          d_err_l <= d_err_now_p0;
        end
        D_BURST: if (d_fire_p0) begin
          if (d_cnt == CNT_W'(1)) d_st <= D_IDLE;
          d_cnt   <= d_cnt - CNT_W'(1);
          d_err_l <= d_err_now_p0;
        end
        default: d_st <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (a_first_p0) begin
      a_src_l  <= a_source;
      a_op_l   <= a_opcode;
      a_size_l <= a_size;
    end
    if (d_first_p0) d_src_l <= d_source;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_vld <= '0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        if (a_first_p0 && (a_source == SOURCE_BITS'(i)))
          ent_vld[i] <= 1'b1;
        else if (d_retire_p0 && (d_tsrc_p0 == SOURCE_BITS'(i)))
          ent_vld[i] <= 1'b0;
      end
    end
  end

  // Latency counts from 1 in the cycle after allocation; invalid entries count harmlessly
  always_ff @(posedge clock) begin
    for (int i = 0; i < NENT; i++) begin
      if (a_first_p0 && (a_source == SOURCE_BITS'(i))) begin
        ent_op[i]   <= a_opcode;
        ent_size[i] <= a_size;
        ent_dop[i]  <= (a_opcode <= 3'd1) ? 3'd0 : 3'd1;
        ent_lat[i]  <= LAT_BITS'(1);
      end else begin
        ent_lat[i]  <= sat_inc(ent_lat[i]);
      end
    end
  end

  // Stage p1: registered report outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      done_valid      <= 1'b0;
      done_source     <= '0;
      done_opcode     <= '0;
      done_latency    <= '0;
      done_error      <= 1'b0;
      err_valid       <= 1'b0;
      err_mask        <= '0;
      err_a_source    <= '0;
      err_d_source    <= '0;
      outstanding_cnt <= '0;
    end else begin
      done_valid <= d_retire_p0;
      if (d_retire_p0) begin
        done_source  <= d_tsrc_p0;
        done_opcode  <= ent_op[d_tsrc_p0];
        done_latency <= ent_lat[d_tsrc_p0];
        done_error   <= d_err_now_p0;
      end
      err_valid <= |err_mask_p0;
      err_mask  <= err_mask_p0;
      if (a_dup_p0 || a_chg_p0)  err_a_source <= a_source;
      if (d_miss_p0 || d_mis_p0) err_d_source <= d_source;
      if (a_new_p0 && !d_retire_p0)
        outstanding_cnt <= outstanding_cnt + OC_W'(1);
      else if (!a_new_p0 && d_retire_p0)
        outstanding_cnt <= outstanding_cnt - OC_W'(1);
    end
  end

endmodule

// File: doc/sifive_insight_tl_txn_tracker.md
SIFIVE_INSIGHT_TL_TXN_TRACKER -- requirements
Module: sifive_insight_tl_txn_tracker

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  SOURCE_BITS  2   a_source/d_source width; 2^SOURCE_BITS tracker entries.
  SIZE_BITS    3   a_size/d_size width (log2 bytes).
  BEAT_LG      3   log2 of data-beat bytes.
  LAT_BITS     16  latency counter width.
REQ-002 Ports, one per line: name  direction  width  meaning. Clock and reset come first.
  clock  in  1  single clock, all logic on rising edge.
  reset  in  1  synchronous, active-high.
  a_valid / a_ready  in  1 each  A-channel handshake, observed only.
  a_opcode  in  3  TileLink A opcode.
  a_size  in  SIZE_BITS  A request size.
  a_source  in  SOURCE_BITS  A request source ID.
  d_valid / d_ready  in  1 each  D-channel handshake, observed only.
  d_opcode  in  3  TileLink D opcode.
  d_size  in  SIZE_BITS  D response size.
  d_source  in  SOURCE_BITS  D response source ID.
  d_denied / d_corrupt  in  1 each  D status bits.
  done_valid  out  1  one-cycle pulse when a transaction retires.
  done_source  out  SOURCE_BITS  ID of the retired transaction.
  done_opcode  out  3  A opcode of the retired transaction.
  done_latency  out  LAT_BITS  cycle count from the A first beat to the D last beat.
  done_error  out  1  denied, corrupt, or response mismatch.
  err_valid  out  1  one-cycle pulse on a protocol violation.
  err_mask  out  4  bit0 A duplicate source; bit1 A mid-burst field change; bit2 D source not outstanding; bit3 D opcode/size mismatch.
  err_a_source / err_d_source  out  SOURCE_BITS each  offending IDs.
  outstanding_cnt  out  SOURCE_BITS+1  number of live entries.
REQ-003 The block SHALL be a passive monitor of the D-cache/data TileLink bundle with no outputs that drive the bus.
REQ-004 Supported A opcodes are 0 to 4; A opcodes 5 to 7 SHALL be ignored, with no allocation and no error.

Function
REQ-005 A beat fires when a_valid&a_ready; a D beat fires when d_valid&d_ready.
REQ-006 Beat count SHALL be max(1, 2^(size-BEAT_LG)) for data-carrying messages (A opcodes 0-3, D opcode 1), and 1 otherwise.
REQ-007 A-side FSM: A_IDLE -> A_BURST on a first-beat fire with remaining beats >1; A_BURST -> A_IDLE on the last-beat fire.
REQ-008 A-side latch: source, opcode and size SHALL be latched on the first beat.
REQ-009 A-side field checks: a subsequent beat whose source, opcode or size differs SHALL set err bit1; the burst still counts down.
REQ-010 Allocation SHALL occur on the A first beat only: set entry valid; store opcode, size and expected D opcode (0 for opcodes 0-1, 1 for opcodes 2-4); set the latency counter to 1.
REQ-011 A first beat on an already-valid entry SHALL set err bit0 and re-arm the entry with the new request; the old request is dropped with no done.
REQ-012 Each valid entry's latency counter SHALL increment by 1 per cycle and saturate at 2^LAT_BITS-1.
REQ-013 D side SHALL keep one beat counter, with burst tracking identical to the A side.
REQ-014 D-side entry check: a D first beat for a non-valid entry SHALL set err bit2, track the burst, retire nothing and produce no done.
REQ-015 D-side mismatch: a D first beat with d_opcode or d_size differing from the entry SHALL set err bit3.
REQ-016 D-side retirement: on the D last beat for a valid entry, the entry SHALL retire.
REQ-017 D-side error flag: done_error = OR of d_denied/d_corrupt over all beats, OR the err bit3 condition.
REQ-018 Latency: A first beat firing in cycle t and D last beat in cycle t+N SHALL give done_latency=N, with minimum N=1.
REQ-019 A D first beat in the same cycle as the A allocation of the same source SHALL NOT match it (no bypass) and SHALL set err bit2.
REQ-020 D last beat and A first beat on the same source in the same cycle: the old entry SHALL retire (done) and the new one SHALL allocate, with no error.
REQ-021 done_* and err_* SHALL be registered, asserting the cycle after the causing fire; multiple error bits may set together.
REQ-022 outstanding_cnt SHALL be registered and change by -1, 0 or +1 per cycle.

Reset
REQ-023 While reset is high, all entries, beat counters and FSMs SHALL clear, with the FSMs going to A_IDLE/D_IDLE.
REQ-024 Reset values: done_valid=0, err_valid=0, err_mask=0, outstanding_cnt=0, and all other outputs 0.
REQ-025 Reset mid-burst SHALL abandon the burst; the next fire after reset is a first beat.

Verification
REQ-026 Get src=2 size=3 at cycle 10, AccessAckData size=3 src=2 at cycle 15 -> cycle 16: done_valid=1, done_source=2, done_opcode=4, done_latency=5, done_error=0, outstanding_cnt 1->0.
REQ-027 PutFull size=5 (4 beats, cycles 0-3) src=1, AccessAck at cycle 7 -> done_latency=7, outstanding_cnt=1 from cycle 1 until cycle 8.
REQ-028 Get src=0 outstanding, second Get src=0 -> err_mask=0001, err_a_source=0, outstanding_cnt stays 1.
REQ-029 AccessAck src=3 with no entry -> err_mask=0100, err_d_source=3, no done.
REQ-030 Get src=1 size=4 answered by AccessAckData size=4 with d_corrupt on the second beat only -> done_error=1; Get answered with AccessAck -> err_mask=1000, done_error=1.
REQ-031 Reset asserted during the second beat of a 4-beat PutFull -> all outputs 0; a following single-beat Get allocates normally.
